// File: rtl/fl_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fl_frame_arbiter
// Purpose  : Frame-granular round-robin arbiter merging PORTS FrameLink
//            input streams onto one FrameLink output. A granted frame is
//            never interleaved with another. FrameLink controls are active-low.
// Options  : FL_FRAME_ARBITER_STATS_EN adds per-port completed-frame counters
//            on FRAME_CNT; otherwise FRAME_CNT is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fl_frame_arbiter #(
    parameter int  DATA_WIDTH = 64,
    parameter int  PORTS      = 4,
    localparam int REM_WIDTH  = $clog2(DATA_WIDTH / 8)
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [PORTS*DATA_WIDTH-1:0] RX_DATA,
    input  logic [PORTS*REM_WIDTH-1:0]  RX_REM,
    input  logic [PORTS-1:0]            RX_SOF_N,
    input  logic [PORTS-1:0]            RX_EOF_N,
    input  logic [PORTS-1:0]            RX_SOP_N,
    input  logic [PORTS-1:0]            RX_EOP_N,
    input  logic [PORTS-1:0]            RX_SRC_RDY_N,
    output logic [PORTS-1:0]            RX_DST_RDY_N,
    output logic [DATA_WIDTH-1:0]       TX_DATA,
    output logic [REM_WIDTH-1:0]        TX_REM,
    output logic                        TX_SOF_N,
    output logic                        TX_EOF_N,
    output logic                        TX_SOP_N,
    output logic                        TX_EOP_N,
    output logic                        TX_SRC_RDY_N,
    input  logic                        TX_DST_RDY_N,
    output logic [PORTS*32-1:0]         FRAME_CNT
);

    localparam int GW = $clog2(PORTS);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]            state;
    logic [GW-1:0]         grant;
    logic [GW-1:0]         last;
    logic [GW-1:0]         pick;
    logic                  found;
    logic                  locked;
    logic                  xfer;
    logic                  frame_end;
    logic [PORTS-1:0]      req;
    logic [DATA_WIDTH-1:0] data_arr [PORTS];
    logic [REM_WIDTH-1:0]  rem_arr  [PORTS];

    // Unpack the flat per-port buses so the output mux can index by grant.
    generate
        for (genvar i = 0; i < PORTS; i++) begin : g_slice
            assign data_arr[i] = RX_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            assign rem_arr[i]  = RX_REM[i*REM_WIDTH +: REM_WIDTH];
        end
    endgenerate

    assign req       = ~RX_SRC_RDY_N;
    assign locked    = (state == ST_LOCKED);
    assign xfer      = locked & ~RX_SRC_RDY_N[grant] & ~TX_DST_RDY_N;
    assign frame_end = xfer & ~RX_EOF_N[grant];

    // Round-robin pick: first requester scanning last+1, last+2, ... with wrap.
    always_comb begin
        int cand;
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int k = 1; k <= PORTS; k++) begin
            cand = (int'(last) + k) % PORTS;
            if (!found && req[cand[GW-1:0]]) begin
                found = 1'b1;
                pick  = cand[GW-1:0];
            end
        end
    end

    // Output mux: granted slice passes straight through; idle drives inactive.
    always_comb begin
        TX_DATA      = '0;
        TX_REM       = '0;
        TX_SOF_N     = 1'b1;
        TX_EOF_N     = 1'b1;
        TX_SOP_N     = 1'b1;
        TX_EOP_N     = 1'b1;
        TX_SRC_RDY_N = 1'b1;
        RX_DST_RDY_N = '1;
        if (locked) begin
            TX_DATA             = data_arr[grant];
            TX_REM              = rem_arr[grant];
            TX_SOF_N            = RX_SOF_N[grant];
            TX_EOF_N            = RX_EOF_N[grant];
            TX_SOP_N            = RX_SOP_N[grant];
            TX_EOP_N            = RX_EOP_N[grant];
            TX_SRC_RDY_N        = RX_SRC_RDY_N[grant];
            RX_DST_RDY_N[grant] = TX_DST_RDY_N;
        end
    end

    // Arbitration FSM: lock on a winner, release only on the granted EOF beat.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            grant <= '0;
            last  <= GW'(PORTS - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant <= pick;
                        state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (frame_end) begin
                        last  <= grant;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FL_FRAME_ARBITER_STATS_EN
    logic [31:0] frame_cnt [PORTS];

    // Completed-frame counters, wrapping naturally at 32 bits.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < PORTS; i++) begin
                frame_cnt[i] <= '0;
            end
        end else if (frame_end) begin
            frame_cnt[grant] <= frame_cnt[grant] + 32'd1;
        end
    end

    generate
        for (genvar i = 0; i < PORTS; i++) begin : g_cnt_out
            assign FRAME_CNT[32*i +: 32] = frame_cnt[i];
        end
    endgenerate
`else
    assign FRAME_CNT = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fl_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fl_frame_arbiter
// Purpose  : Self-checking bench for fl_frame_arbiter: per-port beat queues,
//            a rule-level arbitration model, table scenarios and hand-written
//            backpressure / reset / counter-wrap sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fl_frame_arbiter;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int RW = 3;

    logic           clk;
    logic           rst;
    logic [NP*DW-1:0] rx_data;
    logic [NP*RW-1:0] rx_rem;
    logic [NP-1:0]  sof, eof, sop, eop, src, dst_out;
    logic [DW-1:0]  tx_data;
    logic [RW-1:0]  tx_rem;
    logic           tx_sof, tx_eof, tx_sop, tx_eop, tx_src, tx_dst;
    logic [NP*32-1:0] frame_cnt;

    fl_frame_arbiter #(.DATA_WIDTH(DW), .PORTS(NP)) dut (
        .CLK(clk), .RESET(rst),
        .RX_DATA(rx_data), .RX_REM(rx_rem),
        .RX_SOF_N(sof), .RX_EOF_N(eof), .RX_SOP_N(sop), .RX_EOP_N(eop),
        .RX_SRC_RDY_N(src), .RX_DST_RDY_N(dst_out),
        .TX_DATA(tx_data), .TX_REM(tx_rem),
        .TX_SOF_N(tx_sof), .TX_EOF_N(tx_eof), .TX_SOP_N(tx_sop), .TX_EOP_N(tx_eop),
        .TX_SRC_RDY_N(tx_src), .TX_DST_RDY_N(tx_dst),
        .FRAME_CNT(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  rem;
        logic        sof_n;
        logic        eof_n;
    } beat_t;

    typedef struct {
        int nfr [NP];
        int len [NP];      // 0 selects a random length 1..4 per frame
        int stall;         // percent of cycles with TX_DST_RDY_N = 1
        int gap;           // percent of cycles a source withholds its beat
        int exp_cycles;    // -1: not checked
        int exp_order [8]; // -1 terminates
        int exp_cnt [NP];  // -1: not checked
    } vec_t;

    beat_t       q [NP][$];
    int          order [$];
    int          checks = 0;
    int          errors = 0;
    int          stall_pct = 0;
    int          gap_pct = 0;
    logic        force_stall = 1'b0;
    logic        hold_chk = 1'b0;

    // Rule-level model of the arbiter
    logic        m_locked;
    int          m_grant;
    int          m_last;
    logic [31:0] m_cnt [NP];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_locked = 1'b0;
        m_grant  = 0;
        m_last   = NP - 1;
        for (int p = 0; p < NP; p++) m_cnt[p] = '0;
    endtask

    function automatic logic [NP*32-1:0] exp_fc();
        logic [NP*32-1:0] v;
        v = '0;
`ifdef FL_FRAME_ARBITER_STATS_EN
        for (int p = 0; p < NP; p++) v[p*32 +: 32] = m_cnt[p];
`endif
        return v;
    endfunction

    // Present each queue head (or an idle bus) and choose TX backpressure.
    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            logic gated;
            gated = (gap_pct > 0) && ($urandom_range(99) < gap_pct);
            if (q[p].size() > 0 && !gated) begin
                rx_data[p*DW +: DW] = q[p][0].data;
                rx_rem[p*RW +: RW]  = q[p][0].rem;
                sof[p] = q[p][0].sof_n;
                sop[p] = q[p][0].sof_n;
                eof[p] = q[p][0].eof_n;
                eop[p] = q[p][0].eof_n;
                src[p] = 1'b0;
            end else begin
                rx_data[p*DW +: DW] = '0;
                rx_rem[p*RW +: RW]  = '0;
                sof[p] = 1'b1; sop[p] = 1'b1; eof[p] = 1'b1; eop[p] = 1'b1;
                src[p] = 1'b1;
            end
        end
        tx_dst = force_stall ? 1'b1 :
                 ((stall_pct > 0) && ($urandom_range(99) < stall_pct));
    endtask

    // One clock: compare at negedge, advance model and sources, redrive.
    task automatic step();
        logic [75:0] exp_b, act_b;
        logic [3:0]  dv;
        logic        found;
        @(negedge clk);
        if (m_locked) begin
            dv = 4'hF;
            dv[m_grant] = tx_dst;
            exp_b = {src[m_grant], sof[m_grant], eof[m_grant], sop[m_grant], eop[m_grant],
                     dv, rx_rem[m_grant*RW +: RW], rx_data[m_grant*DW +: DW]};
        end else begin
            exp_b = {1'b1, 4'hF, 4'hF, 3'b000, 64'h0};
        end
        act_b = {tx_src, tx_sof, tx_eof, tx_sop, tx_eop, dst_out, tx_rem, tx_data};
        check("cycle", 128'(act_b), 128'(exp_b));
        check("frame_cnt", 128'(frame_cnt), 128'(exp_fc()));
        if (hold_chk) begin
            check("hold_tag", 128'(tx_data[63:40]), 128'(24'h010001));
            check("p3_dst", 128'(dst_out[3]), 128'(1'b1));
        end
        if (!tx_src && !tx_dst && !tx_sof) order.push_back(int'(tx_data[63:56]));
        for (int p = 0; p < NP; p++)
            if (!src[p] && !dst_out[p] && q[p].size() > 0) void'(q[p].pop_front());
        if (rst) begin
            m_reset();
        end else if (!m_locked) begin
            found = 1'b0;
            for (int k = 1; k <= NP; k++) begin
                if (!found && !src[(m_last + k) % NP]) begin
                    found    = 1'b1;
                    m_grant  = (m_last + k) % NP;
                    m_locked = 1'b1;
                end
            end
        end else if (!src[m_grant] && !tx_dst && !eof[m_grant]) begin
            m_cnt[m_grant] = m_cnt[m_grant] + 32'd1;
            m_last   = m_grant;
            m_locked = 1'b0;
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        for (int p = 0; p < NP; p++) q[p].delete();
        stall_pct = 0; gap_pct = 0; force_stall = 1'b0;
        rst = 1'b1;
        m_reset();
        drive();
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
    endtask

    task automatic push_frame(input int p, input int f, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data  = {8'(p), 8'(f), 8'(i), 8'h00, $urandom()};
            b.rem   = (len == 3 && p == 2) ? 3'd7 : 3'($urandom_range(7));
            b.sof_n = (i != 0);
            b.eof_n = (i != len - 1);
            q[p].push_back(b);
        end
    endtask

    function automatic logic all_empty();
        for (int p = 0; p < NP; p++) if (q[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_to_empty(input int budget, output int cyc);
        cyc = 0;
        while (!all_empty() && cyc < budget) begin
            step();
            cyc++;
        end
        if (!all_empty()) check("timeout", 128'(cyc), 128'(budget + 1));
        repeat (2) step();
    endtask

    vec_t tbl [6];

    initial begin
        int cyc;
        logic [NP*32-1:0] cexp;
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [31:0] cexp;
        rst = 1'b1; tx_dst = 1'b1;
        rx_data = '0; rx_rem = '0;
        sof = '1; eof = '1; sop = '1; eop = '1; src = '1;

        // Scenario table
        tbl[0].nfr = '{0,0,1,0}; tbl[0].len = '{1,1,3,1}; tbl[0].stall = 0; tbl[0].gap = 0;
        tbl[0].exp_cycles = 4;  tbl[0].exp_order = '{2,-1,-1,-1,-1,-1,-1,-1};
        tbl[0].exp_cnt = '{0,0,1,0};
        tbl[1].nfr = '{2,2,2,2}; tbl[1].len = '{2,2,2,2}; tbl[1].stall = 0; tbl[1].gap = 0;
        tbl[1].exp_cycles = 24; tbl[1].exp_order = '{0,1,2,3,0,1,2,3};
        tbl[1].exp_cnt = '{2,2,2,2};
        tbl[2].nfr = '{2,2,0,0}; tbl[2].len = '{1,1,1,1}; tbl[2].stall = 0; tbl[2].gap = 0;
        tbl[2].exp_cycles = 8;  tbl[2].exp_order = '{0,1,0,1,-1,-1,-1,-1};
        tbl[2].exp_cnt = '{2,2,0,0};
        tbl[3].nfr = '{0,2,0,2}; tbl[3].len = '{1,3,1,2}; tbl[3].stall = 0; tbl[3].gap = 0;
        tbl[3].exp_cycles = 14; tbl[3].exp_order = '{1,3,1,3,-1,-1,-1,-1};
        tbl[3].exp_cnt = '{0,2,0,2};
        tbl[4].nfr = '{5,0,2,0}; tbl[4].len = '{2,1,1,1}; tbl[4].stall = 0; tbl[4].gap = 0;
        tbl[4].exp_cycles = 19; tbl[4].exp_order = '{0,2,0,2,0,0,0,-1};
        tbl[4].exp_cnt = '{5,0,2,0};
        tbl[5].nfr = '{4,4,4,4}; tbl[5].len = '{0,0,0,0}; tbl[5].stall = 30; tbl[5].gap = 20;
        tbl[5].exp_cycles = -1; tbl[5].exp_order = '{-1,-1,-1,-1,-1,-1,-1,-1};
        tbl[5].exp_cnt = '{4,4,4,4};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int p = 0; p < NP; p++)
                for (int f = 0; f < tbl[v].nfr[p]; f++)
                    push_frame(p, f, tbl[v].len[p] == 0 ? $urandom_range(1, 4) : tbl[v].len[p]);
            stall_pct = tbl[v].stall;
            gap_pct   = tbl[v].gap;
            order.delete();
            drive();
            run_to_empty(3000, cyc);
            if (tbl[v].exp_cycles >= 0) check("cycles", 128'(cyc), 128'(tbl[v].exp_cycles));
            for (int i = 0; i < 8; i++)
                if (tbl[v].exp_order[i] >= 0)
                    check("order", 128'(order.size() > i ? order[i] : -1), 128'(tbl[v].exp_order[i]));
            for (int p = 0; p < NP; p++) begin
`ifdef FL_FRAME_ARBITER_STATS_EN
                cexp = 32'(tbl[v].exp_cnt[p]);
`else
                cexp = 32'd0;
`endif
                check("cnt_final", 128'(frame_cnt[p*32 +: 32]), 128'(cexp));
            end
        end

        // Backpressure mid-frame on port 1 while port 3 waits
        do_reset();
        push_frame(1, 0, 4);
        push_frame(3, 0, 2);
        order.delete();
        drive();
        step();
        step();
        force_stall = 1'b1;
        tx_dst = 1'b1;
        hold_chk = 1'b1;
        repeat (10) step();
        hold_chk = 1'b0;
        force_stall = 1'b0;
        tx_dst = 1'b0;
        run_to_empty(200, cyc);
        check("bp_order0", 128'(order.size() > 0 ? order[0] : -1), 128'(1));
        check("bp_order1", 128'(order.size() > 1 ? order[1] : -1), 128'(3));

        // Reset after beat 2 of a 5-beat frame on port 3
        do_reset();
        push_frame(3, 0, 5);
        drive();
        repeat (3) step();
        push_frame(0, 0, 2);
        rst = 1'b1;
        drive();
        step();
        rst = 1'b0;
        drive();
        check("rst_dst", 128'(dst_out), 128'(4'hF));
        check("rst_txsrc", 128'(tx_src), 128'(1'b1));
        check("rst_cnt", 128'(frame_cnt), 128'(0));
        order.delete();
        run_to_empty(200, cyc);
        check("rst_order0", 128'(order.size() > 0 ? order[0] : -1), 128'(0));

`ifdef FL_FRAME_ARBITER_STATS_EN
        // Counter wrap from all-ones
        do_reset();
        dut.frame_cnt[0] = 32'hFFFF_FFFF;
        m_cnt[0] = 32'hFFFF_FFFF;
        push_frame(0, 0, 2);
        drive();
        run_to_empty(200, cyc);
        check("wrap", 128'(frame_cnt[31:0]), 128'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
